// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the HC4051 scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_SETTLE,
    ST_CONVERT,
    ST_WAIT_ADC,
    ST_OUTPUT
  } state_e;

  // Lowest set bit of a channel mask; returns 0 for an empty mask.
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [ADDR_W-1:0] ch;
    ch = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (mask[i-1]) ch = ADDR_W'(i - 1);
    end
    return ch;
  endfunction

endpackage

// File: rtl/mux_scan_prio_next.sv
// Finds the next set mask bit strictly above the current channel.
module mux_scan_prio_next
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [ADDR_W-1:0] cur_i,
  output logic [ADDR_W-1:0] next_o,
  output logic              found_o
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (mask_i[i-1] && ((i - 1) > 32'(cur_i))) begin
        next_o  = ADDR_W'(i - 1);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an 8:1 analog mux through masked channels with break-before-make
// and settling, triggers one ADC conversion per channel and hands tagged
// results downstream over valid/ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned BBM_CYCLES     = 2,
  parameter int unsigned ADC_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RESET_,
  input  logic                 START,
  input  logic                 CONTINUOUS,
  input  logic [NUM_CH-1:0]    CH_MASK,
  output logic [ADDR_W-1:0]    S,
  output logic                 ENABLE_,
  output logic                 ADC_CONVERT,
  input  logic                 ADC_DONE,
  input  logic [ADC_WIDTH-1:0] ADC_DATA,
  output logic                 RESULT_VALID,
  input  logic                 RESULT_READY,
  output logic [ADDR_W-1:0]    RESULT_CH,
  output logic [ADC_WIDTH-1:0] RESULT_DATA,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR
);

  localparam int unsigned MAX_A   = (SETTLE_CYCLES > BBM_CYCLES) ? SETTLE_CYCLES : BBM_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] BBM_LAST    = CNT_W'(BBM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [ADDR_W-1:0]      s_q, s_d;
  logic                   err_q, err_d;
  logic [ADDR_W-1:0]      rch_q, rch_d;
  logic [ADC_WIDTH-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]      nxt_ch;
  logic                   nxt_found;
  state_e                 adv_state;
  logic [ADDR_W-1:0]      adv_s;
  logic [NUM_CH-1:0]      adv_mask;

  mux_scan_prio_next u_prio (
    .mask_i  (mask_q),
    .cur_i   (s_q),
    .next_o  (nxt_ch),
    .found_o (nxt_found)
  );

  // Where to go after a channel finishes (result accepted or ADC timeout).
  always_comb begin
    adv_state = ST_IDLE;
    adv_s     = s_q;
    adv_mask  = mask_q;
    if (nxt_found) begin
      adv_state = ST_BREAK;
      adv_s     = nxt_ch;
    end else if (CONTINUOUS && (CH_MASK != '0)) begin
      adv_state = ST_BREAK;
      adv_s     = lowest_set(CH_MASK);
      adv_mask  = CH_MASK;
    end
  end

  // Next-state logic; S and the mask only move on transitions into BREAK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    s_d     = s_q;
    err_d   = err_q;
    rch_d   = rch_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (START && (CH_MASK != '0)) begin
          mask_d  = CH_MASK;
          s_d     = lowest_set(CH_MASK);
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (cnt_q == BBM_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CONVERT: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ADC;
      end
      ST_WAIT_ADC: begin
        if (ADC_DONE) begin
          rch_d   = s_q;
          rdata_d = ADC_DATA;
          state_d = ST_OUTPUT;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = adv_state;
          s_d     = adv_s;
          mask_d  = adv_mask;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (RESULT_READY) begin
          cnt_d   = '0;
          state_d = adv_state;
          s_d     = adv_s;
          mask_d  = adv_mask;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      s_q     <= '0;
      err_q   <= 1'b0;
      rch_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      s_q     <= s_d;
      err_q   <= err_d;
      rch_q   <= rch_d;
      rdata_q <= rdata_d;
    end
  end

  // Mux stays enabled through OUTPUT so a stalled consumer never costs an extra BBM gap.
  assign ENABLE_      = (state_q == ST_IDLE) || (state_q == ST_BREAK);
  assign ADC_CONVERT  = (state_q == ST_CONVERT);
  assign RESULT_VALID = (state_q == ST_OUTPUT);
  assign BUSY         = (state_q != ST_IDLE);
  assign S            = s_q;
  assign RESULT_CH    = rch_q;
  assign RESULT_DATA  = rdata_q;
  assign TIMEOUT_ERR  = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer with a behavioural ADC and a
// mux-timing monitor.
module tb_mux_scan_sequencer;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned BBM    = 2;
  localparam int unsigned AW     = 12;
  localparam int unsigned TMO    = 255;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          continuous;
  logic [7:0]    ch_mask;
  logic [2:0]    s;
  logic          enable_n;
  logic          adc_convert;
  logic          adc_done;
  logic [AW-1:0] adc_data;
  logic          result_valid;
  logic          result_ready;
  logic [2:0]    result_ch;
  logic [AW-1:0] result_data;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int conv_cnt = 0;

  logic [14:0]   exp_q[$];
  logic [14:0]   res_log[$];
  logic [AW-1:0] adc_vals[$];
  bit            mute_en = 1'b0;
  logic [2:0]    mute_ch = '0;

  mux_scan_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .BBM_CYCLES     (BBM),
    .ADC_WIDTH      (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK          (clk),
    .RESET_       (rst_n),
    .START        (start),
    .CONTINUOUS   (continuous),
    .CH_MASK      (ch_mask),
    .S            (s),
    .ENABLE_      (enable_n),
    .ADC_CONVERT  (adc_convert),
    .ADC_DONE     (adc_done),
    .ADC_DATA     (adc_data),
    .RESULT_VALID (result_valid),
    .RESULT_READY (result_ready),
    .RESULT_CH    (result_ch),
    .RESULT_DATA  (result_data),
    .BUSY         (busy),
    .TIMEOUT_ERR  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  // ADC model: answers 3 cycles after a CONVERT strobe and queues the expected result.
  initial begin : adc_model
    int          dly;
    bit          pend;
    logic [2:0]  pch;
    logic [AW-1:0] pdata;
    dly = 0;
    pend = 1'b0;
    pch = '0;
    pdata = '0;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (rst_n !== 1'b1) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (dly == 0) begin
            adc_done = 1'b1;
            adc_data = pdata;
            exp_q.push_back({pch, pdata});
            pend = 1'b0;
          end else begin
            dly--;
          end
        end
        if (adc_convert === 1'b1 && !(mute_en && s == mute_ch)) begin
          pend = 1'b1;
          dly = 2;
          pch = s;
          if (adc_vals.size() > 0) pdata = adc_vals.pop_front();
          else pdata = AW'($urandom);
        end
      end
    end
  end

  // Monitor: scoreboard on handshakes plus break-before-make / settle widths.
  initial begin : monitor
    logic [2:0]  prev_s;
    logic        prev_en;
    int          hi_run;
    int          lo_run;
    bit          armed;
    logic [14:0] e;
    prev_s = '0;
    prev_en = 1'b1;
    hi_run = 0;
    lo_run = 0;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        prev_s = s;
        prev_en = 1'b1;
        hi_run = 0;
        lo_run = 0;
        armed = 1'b0;
      end else begin
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
          res_cnt++;
          res_log.push_back({result_ch, result_data});
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected got ch=%0d data=0x%03h required none", result_ch, result_data);
          end else begin
            e = exp_q.pop_front();
            if ({result_ch, result_data} !== e) begin
              errors++;
              $display("FAIL result got ch=%0d data=0x%03h required ch=%0d data=0x%03h",
                       result_ch, result_data, e[14:12], e[11:0]);
            end
          end
        end
        if (s !== prev_s) begin
          checks++;
          if (enable_n !== 1'b1) begin
            errors++;
            $display("FAIL addr_change_enabled got ENABLE_=%b required 1", enable_n);
          end
        end
        prev_s = s;
        if (enable_n === 1'b1) begin
          if (busy === 1'b1) hi_run++;
          else hi_run = 0;
          armed = 1'b0;
        end else if (prev_en === 1'b1) begin
          checks++;
          if (hi_run != BBM) begin
            errors++;
            $display("FAIL bbm_width got %0d required %0d", hi_run, BBM);
          end
          hi_run = 0;
          armed = 1'b1;
          lo_run = 0;
        end
        if (adc_convert === 1'b1) begin
          conv_cnt++;
          checks++;
          if (!armed || lo_run != SETTLE) begin
            errors++;
            $display("FAIL settle_width got %0d armed=%0d required %0d", lo_run, armed, SETTLE);
          end
          armed = 1'b0;
        end else if (armed) begin
          lo_run++;
        end
        prev_en = enable_n;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    ch_mask = '0;
    result_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (s !== 3'd0 || enable_n !== 1'b1 || adc_convert !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got S=%0d EN_=%b CONV=%b BUSY=%b required 0 1 0 0",
               s, enable_n, adc_convert, busy);
    end
    checks++;
    if (result_valid !== 1'b0 || result_ch !== 3'd0 || result_data !== '0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_result got V=%b CH=%0d D=0x%03h TO=%b required 0 0 0x000 0",
               result_valid, result_ch, result_data, timeout_err);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic_scan();
    int c;
    bit ok;
    logic [14:0] r;
    logic [14:0] want [3];
    want[0] = {3'd0, 12'h123};
    want[1] = {3'd2, 12'h456};
    want[2] = {3'd7, 12'h789};
    res_log.delete();
    result_ready = 1'b1;
    adc_vals.push_back(12'h123);
    adc_vals.push_back(12'h456);
    adc_vals.push_back(12'h789);
    start = 1'b1;
    ch_mask = 8'b1000_0101;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || enable_n !== 1'b1 || s !== 3'd0) begin
      errors++;
      $display("FAIL start_to_break got BUSY=%b EN_=%b S=%0d required 1 1 0", busy, enable_n, s);
    end
    c = 1;
    while (adc_convert !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    checks++;
    if (c != 1 + BBM + SETTLE) begin
      errors++;
      $display("FAIL first_convert_cycle got %0d required %0d", c, 1 + BBM + SETTLE);
    end
    wait_idle(600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_idle got BUSY=%b required 0", busy);
    end
    checks++;
    if (res_log.size() != 3) begin
      errors++;
      $display("FAIL basic_count got %0d required 3", res_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = res_log[i];
        checks++;
        if (r !== want[i]) begin
          errors++;
          $display("FAIL basic_result%0d got ch=%0d data=0x%03h required ch=%0d data=0x%03h",
                   i, r[14:12], r[11:0], want[i][14:12], want[i][11:0]);
        end
      end
    end
    checks++;
    if (s !== 3'd7) begin
      errors++;
      $display("FAIL idle_holds_addr got S=%0d required 7", s);
    end
  endtask

  task automatic test_backpressure();
    int c;
    int cv0;
    bit ok;
    bit stable;
    logic [2:0] hch;
    logic [AW-1:0] hdata;
    res_log.delete();
    result_ready = 1'b0;
    start = 1'b1;
    ch_mask = 8'h03;
    tick();
    start = 1'b0;
    c = 0;
    while (adc_done !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    checks++;
    if (adc_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done_seen got ADC_DONE=%b required 1", adc_done);
    end
    tick();
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_after_done got RESULT_VALID=%b required 1", result_valid);
    end
    hch = result_ch;
    hdata = result_data;
    cv0 = conv_cnt;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (result_valid !== 1'b1 || result_ch !== hch || result_data !== hdata) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold got V=%b CH=%0d D=0x%03h required 1 %0d 0x%03h",
               result_valid, result_ch, result_data, hch, hdata);
    end
    checks++;
    if (conv_cnt != cv0) begin
      errors++;
      $display("FAIL bp_no_convert got %0d converts required 0", conv_cnt - cv0);
    end
    checks++;
    if (hch !== 3'd0) begin
      errors++;
      $display("FAIL bp_channel got %0d required 0", hch);
    end
    result_ready = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0 || s !== 3'd1 || enable_n !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got V=%b S=%0d EN_=%b BUSY=%b required 0 1 1 1",
               result_valid, s, enable_n, busy);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || res_log.size() != 2) begin
      errors++;
      $display("FAIL bp_done got idle=%0d results=%0d required 1 2", ok, res_log.size());
    end
  endtask

  task automatic test_timeout();
    int c;
    bit ok;
    logic [14:0] r;
    res_log.delete();
    result_ready = 1'b1;
    mute_en = 1'b1;
    mute_ch = 3'd3;
    start = 1'b1;
    ch_mask = 8'h18;
    tick();
    start = 1'b0;
    c = 0;
    while (adc_convert !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    checks++;
    if (adc_convert !== 1'b1 || s !== 3'd3) begin
      errors++;
      $display("FAIL to_convert got CONV=%b S=%0d required 1 3", adc_convert, s);
    end
    c = 0;
    while (timeout_err !== 1'b1 && c < TMO + 20) begin
      tick();
      c++;
    end
    checks++;
    if (c != TMO + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d required %0d", c, TMO + 1);
    end
    checks++;
    if (s !== 3'd4 || enable_n !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_advance got S=%0d EN_=%b BUSY=%b required 4 1 1", s, enable_n, busy);
    end
    wait_idle(300, ok);
    mute_en = 1'b0;
    checks++;
    if (!ok || res_log.size() != 1) begin
      errors++;
      $display("FAIL timeout_results got idle=%0d results=%0d required 1 1", ok, res_log.size());
    end else begin
      r = res_log[0];
      checks++;
      if (r[14:12] !== 3'd4) begin
        errors++;
        $display("FAIL timeout_result_ch got %0d required 4", r[14:12]);
      end
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b required 1", timeout_err);
    end
    start = 1'b1;
    ch_mask = 8'h00;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || s !== 3'd4) begin
      errors++;
      $display("FAIL zero_mask_start got BUSY=%b TO=%b S=%0d required 0 1 4", busy, timeout_err, s);
    end
    start = 1'b1;
    ch_mask = 8'h01;
    tick();
    start = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || s !== 3'd0) begin
      errors++;
      $display("FAIL start_clears_err got TO=%b BUSY=%b S=%0d required 0 1 0", timeout_err, busy, s);
    end
    wait_idle(300, ok);
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [14:0] r;
    res_log.delete();
    result_ready = 1'b1;
    start = 1'b1;
    ch_mask = 8'h04;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    ch_mask = 8'hFF;
    tick();
    start = 1'b0;
    checks++;
    if (s !== 3'd2 || busy !== 1'b1 || enable_n !== 1'b0) begin
      errors++;
      $display("FAIL start_during_scan got S=%0d BUSY=%b EN_=%b required 2 1 0", s, busy, enable_n);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || res_log.size() != 1) begin
      errors++;
      $display("FAIL ignored_results got idle=%0d results=%0d required 1 1", ok, res_log.size());
    end else begin
      r = res_log[0];
      checks++;
      if (r[14:12] !== 3'd2 || s !== 3'd2) begin
        errors++;
        $display("FAIL ignored_channel got ch=%0d S=%0d required 2 2", r[14:12], s);
      end
    end
  endtask

  task automatic test_continuous();
    int c;
    bit ok;
    bit all0;
    logic [14:0] r;
    res_log.delete();
    result_ready = 1'b1;
    continuous = 1'b1;
    start = 1'b1;
    ch_mask = 8'h01;
    tick();
    start = 1'b0;
    c = 0;
    while (res_log.size() < 3 && c < 1000) begin
      tick();
      c++;
    end
    checks++;
    if (res_log.size() < 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL continuous_repeat got results=%0d BUSY=%b required >=3 1", res_log.size(), busy);
    end
    ch_mask = 8'h00;
    wait_idle(300, ok);
    continuous = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL continuous_empty_reload got BUSY=%b required 0", busy);
    end
    all0 = 1'b1;
    for (int i = 0; i < res_log.size(); i++) begin
      r = res_log[i];
      if (r[14:12] !== 3'd0) all0 = 1'b0;
    end
    checks++;
    if (!all0) begin
      errors++;
      $display("FAIL continuous_channel got nonzero channel required all 0");
    end
  endtask

  task automatic test_reset_midscan();
    int c;
    result_ready = 1'b1;
    start = 1'b1;
    ch_mask = 8'h02;
    tick();
    start = 1'b0;
    c = 0;
    while (enable_n !== 1'b0 && c < 50) begin
      tick();
      c++;
    end
    repeat (3) tick();
    checks++;
    if (enable_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup got EN_=%b BUSY=%b required 0 1", enable_n, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (enable_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_async_enable got EN_=%b required 1", enable_n);
    end
    checks++;
    if (busy !== 1'b0 || s !== 3'd0 || adc_convert !== 1'b0 || result_valid !== 1'b0 ||
        result_ch !== 3'd0 || result_data !== '0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs got BUSY=%b S=%0d CONV=%b V=%b CH=%0d D=0x%03h TO=%b required all 0",
               busy, s, adc_convert, result_valid, result_ch, result_data, timeout_err);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || enable_n !== 1'b1 || s !== 3'd0) begin
      errors++;
      $display("FAIL rst_release got BUSY=%b EN_=%b S=%0d required 0 1 0", busy, enable_n, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_timeout();
    test_start_ignored();
    test_continuous();
    test_reset_midscan();
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Synchronous controller that drives the address and enable lines of an HC4051-style 8:1 analog multiplexer and collects one ADC conversion per selected channel. Steps through masked channels in ascending order, enforces break-before-make on every address change and a settling delay before each conversion, then hands each tagged result downstream over a valid/ready interface. Sits between the board monitoring logic and the mux/ADC pair on the front-end card.

## Interface
- SETTLE_CYCLES, 16: cycles the mux is enabled on a new address before ADC_CONVERT is issued (≥1).
- BBM_CYCLES, 2: cycles ENABLE_ is held high around an address change (≥1).
- ADC_WIDTH, 12: width of conversion data.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for ADC_DONE (≥1).

- CLK  input  1  single clock; all logic on rising edge.
- RESET_  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request to begin a scan; ignored unless IDLE.
- CONTINUOUS  input  1  when high at end of scan, a new scan begins immediately.
- CH_MASK  input  8  channels to scan; bit n selects mux input Xn; captured at scan start.
- S  output  3  mux address.
- ENABLE_  output  1  mux enable, active-low.
- ADC_CONVERT  output  1  one-cycle conversion strobe.
- ADC_DONE  input  1  conversion-complete strobe from ADC.
- ADC_DATA  input  ADC_WIDTH  conversion result, valid when ADC_DONE high.
- RESULT_VALID  output  1  result available.
- RESULT_READY  input  1  downstream accepts result.
- RESULT_CH  output  3  channel of RESULT_DATA.
- RESULT_DATA  output  ADC_WIDTH  captured conversion.
- BUSY  output  1  high in every state except IDLE.
- TIMEOUT_ERR  output  1  sticky; set on ADC timeout, cleared on accepted START.

## Operation
- States: IDLE, BREAK, SETTLE, CONVERT, WAIT_ADC, OUTPUT.
- IDLE: ENABLE_=1, S holds last value. START with captured mask ≠0 → load mask, pick lowest set bit, clear TIMEOUT_ERR, → BREAK. START with mask=0 → stay IDLE, nothing changes.
- BREAK: ENABLE_=1; S updated to the new channel on the first BREAK cycle; after BBM_CYCLES → SETTLE.
- SETTLE: ENABLE_=0, S stable; after SETTLE_CYCLES → CONVERT.
- CONVERT: ADC_CONVERT=1 for exactly one cycle → WAIT_ADC.
- WAIT_ADC: ENABLE_ stays 0. ADC_DONE sampled only here (a DONE coinciding with CONVERT is ignored). On ADC_DONE: register ADC_DATA and channel → OUTPUT. If TIMEOUT_CYCLES elapse with no DONE: set TIMEOUT_ERR, produce no result, advance as below.
- OUTPUT: RESULT_VALID=1, RESULT_CH/RESULT_DATA stable until RESULT_READY high on a clock edge; then advance.
- Advance: next higher set bit of captured mask → BREAK. None left: CONTINUOUS=1 → reload CH_MASK, restart at lowest bit (if new mask=0 → IDLE); else → IDLE.
- ENABLE_ stays high through IDLE and BREAK; the mux is never enabled while S changes.
- START while BUSY ignored; CH_MASK changes mid-scan ignored.

## Timing
- Reset values: S=0, ENABLE_=1, ADC_CONVERT=0, RESULT_VALID=0, RESULT_CH=0, RESULT_DATA=0, BUSY=0, TIMEOUT_ERR=0; state IDLE. Reset mid-scan forces ENABLE_ high asynchronously; pending result discarded.
- START sampled at edge 0 → BREAK from cycle 1, S valid cycle 1.
- ENABLE_ falls at cycle 1+BBM_CYCLES; ADC_CONVERT high at cycle 1+BBM_CYCLES+SETTLE_CYCLES.
- ADC_DONE sampled at edge k → RESULT_VALID high from cycle k+1.
- Handshake at edge j → next BREAK (or IDLE) at cycle j+1; RESULT_VALID low same cycle.
- Timeout: TIMEOUT_CYCLES-th WAIT_ADC cycle without DONE → TIMEOUT_ERR high next cycle.
- Counters sized for max parameter value; no wrap beyond terminal counts.

## Structure
- Package mux_scan_pkg: state encoding constants, channel count (8), address width (3).
- One sub-module: mux_scan_prio_next — combinational next-set-bit finder (mask, current channel → next channel, found flag).

## Test plan
- CH_MASK=8'b1000_0101, START, ADC responds 3 cycles after CONVERT with 0x123,0x456,0x789, READY tied high → results (0,0x123),(2,0x456),(7,0x789); BUSY falls after ch7.
- Any address change → ENABLE_=1 for exactly BBM_CYCLES with S constant and ENABLE_ low for exactly SETTLE_CYCLES before each ADC_CONVERT.
- RESULT_READY held low 20 cycles → RESULT_VALID/CH/DATA stable, no further CONVERT; ready → next channel BREAK next cycle.
- ADC_DONE never asserted on ch3 of mask 8'h18 → TIMEOUT_ERR after TIMEOUT_CYCLES, no ch3 result, ch4 result produced; START clears flag.
- CH_MASK=0 plus START → stays IDLE; START during scan ignored; CONTINUOUS=1 with mask 8'h01 → repeated ch0 results.
- RESET_ low during SETTLE → ENABLE_=1 immediately, all outputs at reset values, IDLE after release.
